key_sw_io: RTL

Memory-mapped input device for the pushbuttons (KEY) and slide switches (SW) on the processor's data bus. It synchronises and debounces the raw board inputs and keeps per-device Ready/Overrun status. It returns read data combinationally to the MEM stage, where it is muxed into the memory-output path alongside data memory. Read and write side effects on status commit at the clock edge that ends the MEM-stage access.

---
 rtl/io_pkg.sv | 14 +
 rtl/debounce_group.sv | 66 ++++++
 rtl/key_sw_io.sv | 128 ++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared constants for the KEY/SW memory-mapped input device.
package io_pkg;

    // Device register addresses, also used by the top-level bus mux.
    localparam logic [31:0] ADDR_KDATA = 32'hFFFFF080;
    localparam logic [31:0] ADDR_KCTRL = 32'hFFFFF084;
    localparam logic [31:0] ADDR_SDATA = 32'hFFFFF090;
    localparam logic [31:0] ADDR_SCTRL = 32'hFFFFF094;

    // Bit positions inside the status/control registers.
    localparam int unsigned READY_BIT = 0;
    localparam int unsigned OVR_BIT   = 2;

endpackage

// File: rtl/debounce_group.sv
// Two-flop synchroniser plus debounce counter for one group of board inputs.
// The stable value only follows the synchronised sample after it has held an
// unchanged, different value for DEBCYCLES consecutive cycles.
module debounce_group #(
    parameter int unsigned      WIDTH     = 4,
    parameter int unsigned      DEBCYCLES = 4,
    parameter logic [WIDTH-1:0] RSTVAL    = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] stable_o,
    output logic             change_o
);

    localparam int unsigned CW = $clog2(DEBCYCLES + 1);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             load;

    // Synchronise the asynchronous raw inputs into the clk domain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= RSTVAL;
            sync2_q <= RSTVAL;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive cycles the sample differs from the stable value.
    // sync1_q is the next sample, so a pending sample change zeroes the count
    // on the edge where it appears and counting restarts from the new value.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        load     = 1'b0;
        if (sync2_q == stable_q || sync1_q != sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBCYCLES - 1)) begin
            cnt_d    = '0;
            stable_d = sync2_q;
            load     = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Debounce counter and accepted stable value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            stable_q <= RSTVAL;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;
    assign change_o = load;

endmodule

// File: rtl/key_sw_io.sv
// Memory-mapped KEY/SW input device: address decode, Ready/Overrun status
// and the combinational read mux returned to the MEM stage.
module key_sw_io
    import io_pkg::*;
#(
    parameter int unsigned      DBITS     = 32,
    parameter int unsigned      DEBCYCLES = 500000,
    parameter logic [DBITS-1:0] ADDRKDATA = ADDR_KDATA,
    parameter logic [DBITS-1:0] ADDRKCTRL = ADDR_KCTRL,
    parameter logic [DBITS-1:0] ADDRSDATA = ADDR_SDATA,
    parameter logic [DBITS-1:0] ADDRSCTRL = ADDR_SCTRL
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    input  logic [DBITS-1:0] addr,
    input  logic             rden,
    input  logic             wren,
    input  logic [DBITS-1:0] wdata,
    output logic             sel,
    output logic [DBITS-1:0] rdata
);

    logic [3:0] key_stable;
    logic [9:0] sw_stable;
    logic       key_chg, sw_chg;

    logic kready_q, kready_d, kovr_q, kovr_d;
    logic sready_q, sready_d, sovr_q, sovr_d;

    logic hit_kdata, hit_kctrl, hit_sdata, hit_sctrl;
    logic rd_ok, ovr_clr;

    // Only bit OVR_BIT of store data matters; the rest is deliberately ignored.
    logic unused_wdata;
    assign unused_wdata = ^wdata;

    debounce_group #(
        .WIDTH     (4),
        .DEBCYCLES (DEBCYCLES),
        .RSTVAL    (4'hF)
    ) u_key (
        .clk_i    (clk),
        .rst_ni   (RESET_N),
        .raw_i    (KEY),
        .stable_o (key_stable),
        .change_o (key_chg)
    );

    debounce_group #(
        .WIDTH     (10),
        .DEBCYCLES (DEBCYCLES),
        .RSTVAL    (10'h000)
    ) u_sw (
        .clk_i    (clk),
        .rst_ni   (RESET_N),
        .raw_i    (SW),
        .stable_o (sw_stable),
        .change_o (sw_chg)
    );

    assign hit_kdata = (addr == ADDRKDATA);
    assign hit_kctrl = (addr == ADDRKCTRL);
    assign hit_sdata = (addr == ADDRSDATA);
    assign hit_sctrl = (addr == ADDRSCTRL);
    assign sel       = hit_kdata | hit_kctrl | hit_sdata | hit_sctrl;

    // A simultaneous load and store is treated as the store alone.
    assign rd_ok   = rden & ~wren;
    assign ovr_clr = wren & ~wdata[OVR_BIT];

    // Status next-state: a change event always beats a clearing access.
    always_comb begin
        kready_d = kready_q;
        kovr_d   = kovr_q;
        sready_d = sready_q;
        sovr_d   = sovr_q;

        if (key_chg) begin
            kready_d = 1'b1;
            if (kready_q) kovr_d = 1'b1;
        end else begin
            if (rd_ok && hit_kdata)   kready_d = 1'b0;
            if (ovr_clr && hit_kctrl) kovr_d   = 1'b0;
        end

        if (sw_chg) begin
            sready_d = 1'b1;
            if (sready_q) sovr_d = 1'b1;
        end else begin
            if (rd_ok && hit_sdata)   sready_d = 1'b0;
            if (ovr_clr && hit_sctrl) sovr_d   = 1'b0;
        end
    end

    // Ready/Overrun status registers for both groups.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            kready_q <= 1'b0;
            kovr_q   <= 1'b0;
            sready_q <= 1'b0;
            sovr_q   <= 1'b0;
        end else begin
            kready_q <= kready_d;
            kovr_q   <= kovr_d;
            sready_q <= sready_d;
            sovr_q   <= sovr_d;
        end
    end

    // Combinational read mux; zero when no device register is addressed.
    always_comb begin
        rdata = '0;
        if (hit_kdata) begin
            rdata[3:0] = ~key_stable;
        end else if (hit_sdata) begin
            rdata[9:0] = sw_stable;
        end else if (hit_kctrl) begin
            rdata[READY_BIT] = kready_q;
            rdata[OVR_BIT]   = kovr_q;
        end else if (hit_sctrl) begin
            rdata[READY_BIT] = sready_q;
            rdata[OVR_BIT]   = sovr_q;
        end
    end

endmodule
